// File: rtl/axi_full_master_burst_tester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_full_master_burst_tester: writes one INCR burst of 1..LEN, reads it   |
// | back and flags any data/response/last mismatch.  Revision: 1.0            |
// +--------------------------------------------------------------------------+
module axi_full_master_burst_tester #(
    parameter int                          C_M_AXI_ID_WIDTH     = 1,
    parameter int                          C_M_AXI_DATA_WIDTH   = 32,
    parameter int                          C_M_AXI_ADDR_WIDTH   = 6,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = '0,
    parameter int                          C_M_AXI_BURST_LEN    = 16
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              INIT_TXN,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_CMPL = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    beat_q, beat_d;
    logic          init_q, init_d;
    logic          init_prev_q, init_prev_d;
    logic          error_q, error_d;

    logic          w_start;
    logic          w_beat_last;
    logic [DW-1:0] w_beat_data;
    logic          unused_ok;

    assign w_start     = init_q & ~init_prev_q;
    assign w_beat_last = (beat_q == 9'(C_M_AXI_BURST_LEN - 1));
    assign w_beat_data = DW'(beat_q) + DW'(1);
    assign unused_ok   = ^{M_AXI_BID, M_AXI_RID};

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            init_q      <= 1'b0;
            init_prev_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            init_q      <= init_d;
            init_prev_q <= init_prev_d;
            error_q     <= error_d;
        end
    end

    // The beat counter doubles as write index and read-compare index.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        error_d     = error_q;
        init_d      = INIT_TXN;
        init_prev_d = init_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    error_d = 1'b0;
                    beat_d  = '0;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (M_AXI_AWREADY) state_d = S_W;
            end
            S_W: begin
                if (M_AXI_WREADY) begin
                    beat_d = beat_q + 9'd1;
                    if (w_beat_last) state_d = S_B;
                end
            end
            S_B: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) error_d = 1'b1;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (M_AXI_ARREADY) begin
                    beat_d  = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                if (M_AXI_RVALID) begin
                    if ((M_AXI_RDATA != w_beat_data) || (M_AXI_RRESP != 2'b00) ||
                        (M_AXI_RLAST != w_beat_last))
                        error_d = 1'b1;
                    beat_d = beat_q + 9'd1;
                    if (w_beat_last) state_d = S_CMPL;
                end
            end
            S_CMPL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign TXN_DONE      = (state_q == S_CMPL);
    assign ERROR         = error_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = C_M_TARGET_BASE_ADDR;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWVALID = (state_q == S_AW);

    // Gating on the W state keeps WDATA/WLAST at zero outside the data phase.
    assign M_AXI_WDATA   = (state_q == S_W) ? w_beat_data : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (state_q == S_W) && w_beat_last;
    assign M_AXI_WVALID  = (state_q == S_W);
    assign M_AXI_BREADY  = (state_q == S_B);

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = C_M_TARGET_BASE_ADDR;
    assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARVALID = (state_q == S_AR);
    assign M_AXI_RREADY  = (state_q == S_R);

endmodule
`default_nettype wire

// File: tb/tb_axi_full_master_burst_tester.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_axi_full_master_burst_tester: slave models for LEN=16 and LEN=1 DUTs.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))
module tb_axi_full_master_burst_tester;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A (LEN=16) ----------------
    logic init_a, done_a, err_a;
    logic [IW-1:0] awid_a, arid_a, bid_a, rid_a;
    logic [AW-1:0] awaddr_a, araddr_a;
    logic [7:0] awlen_a, arlen_a;
    logic [2:0] awsize_a, arsize_a, awprot_a, arprot_a;
    logic [1:0] awburst_a, arburst_a, bresp_a, rresp_a;
    logic awlock_a, arlock_a;
    logic [3:0] awcache_a, arcache_a, awqos_a, arqos_a;
    logic awvalid_a, awready_a, arvalid_a, arready_a;
    logic [DW-1:0] wdata_a, rdata_a;
    logic [DW/8-1:0] wstrb_a;
    logic wlast_a, wvalid_a, wready_a, bvalid_a, bready_a;
    logic rlast_a, rvalid_a, rready_a;

    axi_full_master_burst_tester #(.C_M_AXI_ID_WIDTH(IW), .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_TARGET_BASE_ADDR('0), .C_M_AXI_BURST_LEN(16)) u_dut_a (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .INIT_TXN(init_a), .TXN_DONE(done_a), .ERROR(err_a),
        .M_AXI_AWID(awid_a), .M_AXI_AWADDR(awaddr_a), .M_AXI_AWLEN(awlen_a), .M_AXI_AWSIZE(awsize_a),
        .M_AXI_AWBURST(awburst_a), .M_AXI_AWLOCK(awlock_a), .M_AXI_AWCACHE(awcache_a),
        .M_AXI_AWPROT(awprot_a), .M_AXI_AWQOS(awqos_a), .M_AXI_AWVALID(awvalid_a), .M_AXI_AWREADY(awready_a),
        .M_AXI_WDATA(wdata_a), .M_AXI_WSTRB(wstrb_a), .M_AXI_WLAST(wlast_a), .M_AXI_WVALID(wvalid_a),
        .M_AXI_WREADY(wready_a), .M_AXI_BID(bid_a), .M_AXI_BRESP(bresp_a), .M_AXI_BVALID(bvalid_a),
        .M_AXI_BREADY(bready_a), .M_AXI_ARID(arid_a), .M_AXI_ARADDR(araddr_a), .M_AXI_ARLEN(arlen_a),
        .M_AXI_ARSIZE(arsize_a), .M_AXI_ARBURST(arburst_a), .M_AXI_ARLOCK(arlock_a), .M_AXI_ARCACHE(arcache_a),
        .M_AXI_ARPROT(arprot_a), .M_AXI_ARQOS(arqos_a), .M_AXI_ARVALID(arvalid_a), .M_AXI_ARREADY(arready_a),
        .M_AXI_RID(rid_a), .M_AXI_RDATA(rdata_a), .M_AXI_RRESP(rresp_a), .M_AXI_RLAST(rlast_a),
        .M_AXI_RVALID(rvalid_a), .M_AXI_RREADY(rready_a));

    // ---------------- instance B (LEN=1) ----------------
    logic init_b, done_b, err_b;
    logic [IW-1:0] awid_b, arid_b, bid_b, rid_b;
    logic [AW-1:0] awaddr_b, araddr_b;
    logic [7:0] awlen_b, arlen_b;
    logic [2:0] awsize_b, arsize_b, awprot_b, arprot_b;
    logic [1:0] awburst_b, arburst_b, bresp_b, rresp_b;
    logic awlock_b, arlock_b;
    logic [3:0] awcache_b, arcache_b, awqos_b, arqos_b;
    logic awvalid_b, awready_b, arvalid_b, arready_b;
    logic [DW-1:0] wdata_b, rdata_b;
    logic [DW/8-1:0] wstrb_b;
    logic wlast_b, wvalid_b, wready_b, bvalid_b, bready_b;
    logic rlast_b, rvalid_b, rready_b;

    axi_full_master_burst_tester #(.C_M_AXI_ID_WIDTH(IW), .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_TARGET_BASE_ADDR('0), .C_M_AXI_BURST_LEN(1)) u_dut_b (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .INIT_TXN(init_b), .TXN_DONE(done_b), .ERROR(err_b),
        .M_AXI_AWID(awid_b), .M_AXI_AWADDR(awaddr_b), .M_AXI_AWLEN(awlen_b), .M_AXI_AWSIZE(awsize_b),
        .M_AXI_AWBURST(awburst_b), .M_AXI_AWLOCK(awlock_b), .M_AXI_AWCACHE(awcache_b),
        .M_AXI_AWPROT(awprot_b), .M_AXI_AWQOS(awqos_b), .M_AXI_AWVALID(awvalid_b), .M_AXI_AWREADY(awready_b),
        .M_AXI_WDATA(wdata_b), .M_AXI_WSTRB(wstrb_b), .M_AXI_WLAST(wlast_b), .M_AXI_WVALID(wvalid_b),
        .M_AXI_WREADY(wready_b), .M_AXI_BID(bid_b), .M_AXI_BRESP(bresp_b), .M_AXI_BVALID(bvalid_b),
        .M_AXI_BREADY(bready_b), .M_AXI_ARID(arid_b), .M_AXI_ARADDR(araddr_b), .M_AXI_ARLEN(arlen_b),
        .M_AXI_ARSIZE(arsize_b), .M_AXI_ARBURST(arburst_b), .M_AXI_ARLOCK(arlock_b), .M_AXI_ARCACHE(arcache_b),
        .M_AXI_ARPROT(arprot_b), .M_AXI_ARQOS(arqos_b), .M_AXI_ARVALID(arvalid_b), .M_AXI_ARREADY(arready_b),
        .M_AXI_RID(rid_b), .M_AXI_RDATA(rdata_b), .M_AXI_RRESP(rresp_b), .M_AXI_RLAST(rlast_b),
        .M_AXI_RVALID(rvalid_b), .M_AXI_RREADY(rready_b));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected W beats {wlast, wdata}, filled when a start is driven.
    logic [DW:0] wq [$];
    int  bp = 0;
    int  inj = 0;
    bit  b_pend, r_act, w_stall;
    int  r_idx, w_cyc, r_cyc, w_hs_cnt;
    logic [DW-1:0] w_prev_d;
    logic w_prev_l;

    function automatic logic rnd_or_one();
        return (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Slave A: drive inputs for the next posedge, then score the handshakes it will see.
    always @(negedge clk) begin
        if (rst) begin
            awready_a = 0; wready_a = 0; arready_a = 0; bvalid_a = 0; rvalid_a = 0;
            bresp_a = 0; rresp_a = 0; rlast_a = 0; rdata_a = '0; bid_a = '0; rid_a = '0;
            b_pend = 0; r_act = 0; r_idx = 0; w_stall = 0;
        end else begin
            awready_a = rnd_or_one();
            wready_a  = rnd_or_one();
            arready_a = rnd_or_one();
            bvalid_a  = b_pend && rnd_or_one();
            bresp_a   = (inj == 2) ? 2'b10 : 2'b00;
            rvalid_a  = r_act && rnd_or_one();
            rdata_a   = (inj == 1 && r_idx == 4) ? DW'(32'hFF) : DW'(r_idx + 1);
            rlast_a   = (inj == 4) ? 1'b0 : (inj == 3) ? (r_idx == 13) : (r_idx == 15);
            rresp_a   = 2'b00;
            if (wvalid_a) w_cyc++;
            if (rready_a) r_cyc++;
            if (w_stall) begin
                `CHK("w_stable_data", wdata_a, w_prev_d);
                `CHK("w_stable_last", wlast_a, w_prev_l);
            end
            w_stall  = wvalid_a && !wready_a;
            w_prev_d = wdata_a;
            w_prev_l = wlast_a;
            if (awvalid_a && awready_a) begin
                `CHK("awaddr", awaddr_a, 0);
                `CHK("awlen", awlen_a, 15);
                `CHK("awsize", awsize_a, 2);
                `CHK("awburst", awburst_a, 1);
                `CHK("awcache", awcache_a, 3);
                `CHK("aw_zero_fields", {awid_a, awlock_a, awprot_a, awqos_a}, 0);
            end
            if (wvalid_a && wready_a) begin
                logic [DW:0] e;
                w_hs_cnt++;
                checks++;
                assert (wq.size() > 0) else begin
                    errors++;
                    $error("FAIL w_extra_beat: observed data 0x%0h expected no beat", wdata_a);
                end
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    `CHK("wdata", wdata_a, e[DW-1:0]);
                    `CHK("wlast", wlast_a, e[DW]);
                    `CHK("wstrb", wstrb_a, 4'hF);
                end
                if (wlast_a) b_pend = 1;
            end
            if (bvalid_a && bready_a) b_pend = 0;
            if (arvalid_a && arready_a) begin
                `CHK("ar_after_b", b_pend, 0);
                `CHK("araddr", araddr_a, 0);
                `CHK("arlen", arlen_a, 15);
                `CHK("arsize", arsize_a, 2);
                `CHK("arburst_cache", {arburst_a, arcache_a}, 6'b01_0011);
                r_act = 1;
                r_idx = 0;
            end
            if (rvalid_a && rready_a) begin
                r_idx++;
                if (r_idx == 16) r_act = 0;
            end
        end
    end

    // Slave B: always-ready single-beat responder.
    bit bpend_b, ract_b;
    int wb_cnt, rb_cnt;
    always @(negedge clk) begin
        if (rst) begin
            awready_b = 0; wready_b = 0; arready_b = 0; bvalid_b = 0; rvalid_b = 0;
            bresp_b = 0; rresp_b = 0; rlast_b = 0; rdata_b = '0; bid_b = '0; rid_b = '0;
            bpend_b = 0; ract_b = 0;
        end else begin
            awready_b = 1; wready_b = 1; arready_b = 1;
            bvalid_b = bpend_b; rvalid_b = ract_b;
            rdata_b = DW'(1); rlast_b = 1; bresp_b = 0; rresp_b = 0;
            if (awvalid_b && awready_b) `CHK("b_awlen", awlen_b, 0);
            if (wvalid_b && wready_b) begin
                wb_cnt++;
                `CHK("b_wdata", wdata_b, 1);
                `CHK("b_wlast", wlast_b, 1);
                bpend_b = 1;
            end
            if (bvalid_b && bready_b) bpend_b = 0;
            if (arvalid_b && arready_b) begin
                `CHK("b_arlen", arlen_b, 0);
                ract_b = 1;
            end
            if (rvalid_b && rready_b) begin
                rb_cnt++;
                ract_b = 0;
            end
        end
    end

    task automatic check_a_quiet(input string tag);
        `CHK({tag, "_valids"}, {awvalid_a, wvalid_a, arvalid_a}, 0);
        `CHK({tag, "_readys"}, {bready_a, rready_a}, 0);
        `CHK({tag, "_wlast_wdata"}, {wlast_a, wdata_a}, 0);
        `CHK({tag, "_done_err"}, {done_a, err_a}, 0);
    endtask

    task automatic run_a(input string tag, input bit exp_err);
        for (int i = 1; i <= 16; i++) wq.push_back({1'(i == 16), DW'(i)});
        w_cyc = 0; r_cyc = 0; w_hs_cnt = 0;
        @(negedge clk);
        init_a = 1;
        @(negedge clk);
        `CHK({tag, "_aw_early"}, awvalid_a, 0);
        @(negedge clk);
        `CHK({tag, "_aw_latency"}, awvalid_a, 1);
        `CHK({tag, "_err_cleared"}, err_a, 0);
        init_a = 0;
        for (int n = 0; n < 3000 && !done_a; n++) @(negedge clk);
        `CHK({tag, "_done_seen"}, done_a, 1);
        `CHK({tag, "_err_at_done"}, err_a, exp_err);
        `CHK({tag, "_w_beats_left"}, wq.size(), 0);
        if (bp == 0) begin
            `CHK({tag, "_w_cycles"}, w_cyc, 16);
            `CHK({tag, "_r_cycles"}, r_cyc, 16);
        end
        @(negedge clk);
        `CHK({tag, "_done_pulse"}, done_a, 0);
        repeat (3) @(negedge clk);
        `CHK({tag, "_err_sticky"}, err_a, exp_err);
    endtask

    initial begin
        rst = 1; init_a = 1; init_b = 1;
        repeat (3) @(negedge clk);
        check_a_quiet("reset");
        `CHK("reset_b", {awvalid_b, wvalid_b, done_b, err_b}, 0);
        init_a = 0; init_b = 0;
        @(negedge clk);
        rst = 0;
        repeat (4) @(negedge clk);
        check_a_quiet("post_reset_idle");

        bp = 0; inj = 0; run_a("ideal", 0);
        bp = 1; inj = 0; run_a("backpressure", 0);
        bp = 0;
        inj = 1; run_a("bad_rdata", 1);
        inj = 2; run_a("bad_bresp", 1);
        inj = 3; run_a("early_rlast", 1);
        inj = 4; run_a("missing_rlast", 1);
        inj = 0; run_a("clean_after_err", 0);

        // Reset while beat 7 is on the bus.
        for (int i = 1; i <= 16; i++) wq.push_back({1'(i == 16), DW'(i)});
        w_hs_cnt = 0;
        @(negedge clk);
        init_a = 1;
        @(negedge clk);
        init_a = 0;
        for (int n = 0; n < 200 && w_hs_cnt < 6; n++) @(posedge clk);
        #1;
        `CHK("midw_beat7_data", wdata_a, 7);
        #2 rst = 1;
        #1 check_a_quiet("midw_async_reset");
        wq.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        run_a("after_midw_reset", 0);

        // LEN=1 instance.
        wb_cnt = 0; rb_cnt = 0;
        @(negedge clk);
        init_b = 1;
        repeat (2) @(negedge clk);
        init_b = 0;
        for (int n = 0; n < 200 && !done_b; n++) @(negedge clk);
        `CHK("len1_done", done_b, 1);
        `CHK("len1_err", err_b, 0);
        `CHK("len1_w_beats", wb_cnt, 1);
        `CHK("len1_r_beats", rb_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`undef CHK
`default_nettype wire
